// File: rtl/AESDefinitions.sv
// Shared AES definitions for the serial SubBytes datapath.
//
// Contents:
//   aes_state_t   - 128-bit AES state. Byte 0 sits in bits [127:120] (FIPS-197
//                   column-major order).
//   fsm_state_t   - control states of sub_bytes_serial.
//   SBOX_FWD      - forward S-box. Entry i is at bits [8*(255-i) +: 8], so the
//                   table reads left to right in the usual printed order.
//   SBOX_INV      - inverse S-box, packed the same way.
//   sbox_byte()   - single byte lookup; the inv input selects the inverse table.
package AESDefinitions;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry b lives at bit offset 8*(255-b); 255-b is simply ~b for an 8-bit b,
  // which keeps the index arithmetic free of width growth.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inv);
    logic [10:0] lo;
    lo = {~b, 3'b000};
    if (inv) begin
      sbox_byte = SBOX_INV[lo +: 8];
    end else begin
      sbox_byte = SBOX_FWD[lo +: 8];
    end
  endfunction

endpackage

// File: rtl/SBoxWord.sv
// Combinational 32-bit S-box: four parallel byte lookups sharing one
// forward/inverse select.
//
// Ports:
//   word_in  [31:0] - four input bytes, most significant byte first.
//   inverse         - 0 = forward S-box, 1 = inverse S-box.
//   word_out [31:0] - substituted bytes, same byte order as word_in.
module SBoxWord
  import AESDefinitions::*;
(
  input  logic [31:0] word_in,
  input  logic        inverse,
  output logic [31:0] word_out
);

  assign word_out[31:24] = sbox_byte(word_in[31:24], inverse);
  assign word_out[23:16] = sbox_byte(word_in[23:16], inverse);
  assign word_out[15:8]  = sbox_byte(word_in[15:8],  inverse);
  assign word_out[7:0]   = sbox_byte(word_in[7:0],   inverse);

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial AES SubBytes / InvSubBytes engine. A 128-bit state is accepted
// through a valid/ready handshake and substituted one 32-bit word per clock
// through a single SBoxWord instance, four cycles per state. The result is
// held in the working register until the consumer takes it; a new state may
// be accepted on the same edge the result is consumed.
//
// Ports:
//   clock              - sole clock, rising edge.
//   reset_n            - asynchronous active-low reset.
//   in_valid/in_ready  - input handshake.
//   in_inverse         - 0 = SubBytes, 1 = InvSubBytes; captured with in_state.
//   in_state [127:0]   - input state, byte 0 in bits [127:120].
//   out_valid/out_ready- output handshake.
//   out_state [127:0]  - working register contents (result once out_valid).
//   busy               - high while a state is being processed or held.
module sub_bytes_serial
  import AESDefinitions::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inverse,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  fsm_state_t state_q;
  fsm_state_t state_d;
  logic [1:0] cnt_q;
  logic       mode_q;
  aes_state_t work_q;

  logic       in_xfer;
  logic       out_xfer;
  logic [31:0] word_sel;
  logic [31:0] word_sub;

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A new state can only enter if the held result leaves on this edge.
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_state = work_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (in_xfer) begin
          state_d = RUN;
        end else if (out_xfer) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word 0 is the most significant 32 bits of the state.
  always_comb begin
    word_sel = work_q[127:96];
    case (cnt_q)
      2'd0: word_sel = work_q[127:96];
      2'd1: word_sel = work_q[95:64];
      2'd2: word_sel = work_q[63:32];
      2'd3: word_sel = work_q[31:0];
      default: word_sel = work_q[127:96];
    endcase
  end

  // The lookup uses the latched mode so in_inverse may change freely mid-run.
  SBoxWord u_sbox_word (
    .word_in  (word_sel),
    .inverse  (mode_q),
    .word_out (word_sub)
  );

  // Working register, mode and word counter. The counter wraps naturally to
  // 0 after word 3, which is also the DONE transition, so no fifth word runs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (in_xfer) begin
      work_q <= in_state;
      mode_q <= in_inverse;
      cnt_q  <= 2'd0;
    end else if (state_q == RUN) begin
      case (cnt_q)
        2'd0: work_q[127:96] <= word_sub;
        2'd1: work_q[95:64]  <= word_sub;
        2'd2: work_q[63:32]  <= word_sub;
        2'd3: work_q[31:0]   <= word_sub;
        default: work_q[127:96] <= word_sub;
      endcase
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial using known SubBytes vectors.
module tb_sub_bytes_serial;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_inverse;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_cmp;
  int n_bad;

  localparam logic [127:0] VEC_PLAIN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC_SUB   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_63    = {16{8'h63}};
  localparam logic [127:0] ALL_52    = {16{8'h52}};

  sub_bytes_serial dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inverse (in_inverse),
    .in_state   (in_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_inverse = 1'b0;
    in_state   = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_cmp++;
    if (out_state !== 128'h0) begin
      n_bad++; $display("FAIL reset_out_state: got %h expected 0", out_state);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // Forward vector, transfer on the first edge after reset release.
  task automatic test_forward();
    in_state   = VEC_PLAIN;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = '0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL fwd_run_%0d: got out_valid=%b busy=%b expected 0/1", k, out_valid, busy);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL fwd_latency: got out_valid=%b expected 1", out_valid);
    end
    n_cmp++;
    if (out_state !== VEC_SUB) begin
      n_bad++; $display("FAIL fwd_result: got %h expected %h", out_state, VEC_SUB);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL fwd_consume: got out_valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_inverse();
    in_state   = VEC_SUB;
    in_inverse = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== VEC_PLAIN) begin
      n_bad++; $display("FAIL inv_result: got valid=%b %h expected 1 %h", out_valid, out_state, VEC_PLAIN);
    end
    out_ready = 1'b1;
    tick();
    out_ready  = 1'b0;
    // Inverse of an all-zero state gives 0x52 in every byte.
    in_state   = '0;
    in_inverse = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== ALL_52) begin
      n_bad++; $display("FAIL inv_zero: got valid=%b %h expected 1 %h", out_valid, out_state, ALL_52);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Result held under back-pressure; offered inputs must not be taken.
  task automatic test_hold();
    in_state   = '0;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_state   = {128{1'b1}};
      in_inverse = k[0];
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_state !== ALL_63 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold_%0d: got valid=%b ready=%b %h expected 1 0 %h", k, out_valid, in_ready, out_state, ALL_63);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Consume and accept on the same edge (continues from DONE in test_hold).
  task automatic test_back_to_back();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_state   = ALL_63;
    in_inverse = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_state !== ALL_63) begin
      n_bad++; $display("FAIL b2b_offer: got ready=%b %h expected 1 %h", in_ready, out_state, ALL_63);
    end
    tick();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_inverse = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: got valid=%b busy=%b expected 0 1", out_valid, busy);
    end
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_early: got valid=%b expected 0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== 128'h0) begin
      n_bad++; $display("FAIL b2b_result: got valid=%b %h expected 1 0", out_valid, out_state);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    in_state   = VEC_PLAIN;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
      n_bad++; $display("FAIL rst_run: got valid=%b busy=%b %h expected 0 0 0", out_valid, busy, out_state);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0) begin
        n_bad++; $display("FAIL rst_after_%0d: got valid=%b ready=%b %h expected 0 1 0", k, out_valid, in_ready, out_state);
      end
      tick();
    end
  endtask

  // Input changes during RUN must not leak into the result.
  task automatic test_toggle();
    in_state   = VEC_PLAIN;
    in_inverse = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_inverse = ~in_inverse;
      in_state   = ~in_state;
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_state !== VEC_SUB) begin
      n_bad++; $display("FAIL toggle_result: got valid=%b %h expected 1 %h", out_valid, out_state, VEC_SUB);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_idle_out_ready();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL idle_out_ready_%0d: got valid=%b busy=%b ready=%b expected 0 0 1", k, out_valid, busy, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_forward();
    test_inverse();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_toggle();
    test_idle_out_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_serial.md
SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, producer presents a state to transform.
REQ-004 SHALL have port in_ready, output, 1, block can accept a state this cycle.
REQ-005 SHALL have port in_inverse, input, 1: 0 = SubBytes, 1 = InvSubBytes; sampled with in_state.
REQ-006 SHALL have port in_state, input, 128, AES state, byte 0 in bits [127:120] (FIPS-197 column-major order).
REQ-007 SHALL have port out_valid, output, 1, out_state holds a completed result.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-009 SHALL have port out_state, output, 128, transformed state, same byte order as in_state.
REQ-010 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; the reset state is IDLE.
REQ-012 Input handshake: transfer occurs on a rising edge where in_valid && in_ready.
REQ-013 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready = 1, else 0.
REQ-014 On transfer: latch in_state into the working register, latch in_inverse into the mode register, clear the word counter to 0, and enter RUN.
REQ-015 RUN: each cycle, substitute 32-bit word cnt (cnt 0 = bits [127:96], cnt 3 = bits [31:0]) via one 4-byte S-box lookup using the latched mode; increment cnt by 1.
REQ-016 Counter is 2 bits; on the cycle cnt = 3 is processed the FSM SHALL enter DONE (no wrap into a fifth word).
REQ-017 Latency: transfer at edge N gives out_valid = 1 after edge N+4, with all 16 bytes substituted.
REQ-018 DONE: out_valid = 1; out_state stable until the output handshake (out_valid && out_ready).
REQ-019 On output handshake without simultaneous input transfer: go to IDLE; out_valid = 0 next cycle.
REQ-020 On output handshake with simultaneous input transfer (DONE, out_ready = 1, in_valid = 1): accept the new state and enter RUN with cnt = 0; back-to-back throughput is 1 state per 5 cycles.
REQ-021 Changes to in_inverse or in_state outside a transfer edge SHALL NOT affect the result in progress.
REQ-022 out_valid SHALL be 0 in IDLE and RUN; out_state is undefined-content-free: it holds the working register value at all times.
REQ-023 out_ready asserted while out_valid = 0 SHALL have no effect.

Reset
REQ-024 reset_n low SHALL immediately force IDLE, cnt = 0, mode = 0, working register = 0, out_valid = 0, busy = 0; in_ready = 1 after release.
REQ-025 Reset asserted during RUN or DONE SHALL discard the in-flight state; no output handshake occurs for it.
REQ-026 First transfer is possible on the first rising edge after reset_n deasserts.

Structure
REQ-027 The 128-bit state typedef, the forward S-box table and the inverse S-box table SHALL reside in the shared AESDefinitions package.
REQ-028 A combinational sub-module SBoxWord SHALL map 32 bits to 32 bits (four parallel byte lookups, inverse select input); sub_bytes_serial instantiates exactly one.

Verification
REQ-029 Transfer in_state 193de3bea0f4e22b9ac68d2ae9f84808, in_inverse 0 -> out_valid 4 cycles later, out_state d42711aee0bf98f1b8b45de51e415230.
REQ-030 Transfer d42711aee0bf98f1b8b45de51e415230 with in_inverse 1 -> out_state 193de3bea0f4e22b9ac68d2ae9f84808.
REQ-031 Transfer all-zero with in_inverse 0, hold out_ready = 0 for 10 cycles -> out_valid stays 1, out_state = 63 repeated 16 times, in_ready = 0 throughout.
REQ-032 In DONE, assert out_ready = 1 and in_valid = 1 with all-63 state, in_inverse 1 -> old result consumed, new result all-zero 5 cycles later.
REQ-033 Pulse reset_n low during RUN (cnt = 2) -> out_valid never asserts for that state, out_state = 0, in_ready = 1 after release.
REQ-034 Toggle in_inverse every cycle during RUN after a forward transfer -> result equals the pure forward SubBytes vector.
